ext_irq_controller: RTL and testbench
=====================================

Name: ext_irq_controller

Overview:
- External interrupt controller upstream of processor_arm.
- Collects N_SRC asynchronous interrupt sources, edge-detects them into a pending register and gates them through a software-writable mask.
- Picks the highest-priority enabled request and drives the core's ExtIRQ input, holding it until the core returns ExtIAck.
- Clears the serviced pending bit on acknowledge and enforces a hold-off gap before the next request.

Parameters:
N_SRC, 8, number of interrupt sources (2..32)
ID_W, 3, width of irq_id; must satisfy 2**ID_W >= N_SRC
HOLDOFF, 4, idle cycles forced after an acknowledge before a new request (0..255)
MASK_RESET, all ones (N_SRC bits), reset value of the mask register

Ports:
CLOCK_50  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
irq_src  input  N_SRC  raw asynchronous interrupt lines; a rising edge requests service
mask_we  input  1  mask register write enable
mask_wdata  input  N_SRC  new mask value, 1 = source enabled
ExtIAck  input  1  acknowledge from processor_arm
ExtIRQ  output  1  registered interrupt request to processor_arm
irq_id  output  ID_W  index of the source currently requested or last serviced
pending  output  N_SRC  pending register
mask  output  N_SRC  mask register

Behaviour:
- Reset, asynchronous and active-high, forces: ExtIRQ=0, irq_id=0, pending=0, mask=MASK_RESET, synchronizer and edge registers=0, hold-off counter=0, FSM=IDLE.
- Reset asserted mid-request drops ExtIRQ immediately and discards all pending requests.
- Input path, per source:
  - Two-flop synchronizer (s1, s2), then a previous-value register prv.
  - rise[i] = s2[i] & ~prv[i].
  - Latency: irq_src[i] first sampled high at edge t0 gives rise[i] after t1 and pending[i]=1 after t2.
  - Level-held sources produce a single rise. Pulses shorter than one clock period are not guaranteed to be captured.
- Pending update each cycle: pending <= (pending & ~clr) | rise.
  - clr is one-hot on irq_id during the acknowledge cycle, zero otherwise.
  - If the same bit is both cleared and set in one cycle, set wins and pending stays 1.
- Mask: mask <= mask_wdata on mask_we. The new value is used by arbitration from the following cycle.
- Arbitration: eligible = pending & mask. The lowest index has the highest priority.
- FSM states IDLE, REQ, HOLD:
  - IDLE:
    - If eligible != 0: irq_id <= lowest set index, ExtIRQ <= 1, go to REQ.
    - ExtIAck is ignored in IDLE.
  - REQ:
    - ExtIRQ stays 1 and irq_id stays frozen, even if mask or pending for the latched source changes. The request is committed once issued.
    - When ExtIAck=1 is sampled: ExtIRQ <= 0, clear pending[irq_id], counter <= HOLDOFF, go to HOLD.
    - Higher-priority arrivals during REQ do not preempt; they are served next.
  - HOLD:
    - Counter decrements by 1 per cycle, saturating at 0.
    - Go to IDLE when counter==0 and ExtIAck==0. A long ExtIAck therefore cannot cause a double acknowledge.
    - With HOLDOFF=0, HOLD lasts exactly 1 cycle if ExtIAck is already low.
- ExtIRQ changes only on clock edges (registered, glitch-free).
- Minimum latency from pending set to ExtIRQ=1 is 1 cycle when in IDLE.
- irq_id holds its value after acknowledge until the next request is issued.
- Sources with index >= N_SRC do not exist. irq_id never exceeds N_SRC-1.

Test Plan:
1. Single source: after reset, pulse irq_src[5] high for 3 cycles → pending=8'h20 after 3 edges, ExtIRQ=1 and irq_id=5 on the next cycle. Hold ExtIAck=1 for 1 cycle → ExtIRQ=0, pending=0, no new request for at least 4 cycles.
2. Priority: raise irq_src[6] and irq_src[2] in the same cycle → first request irq_id=2. After ack and hold-off, second request irq_id=6. pending=0 after both acks.
3. Mask: write mask=8'hFB, then raise irq_src[2] → pending=8'h04, ExtIRQ stays 0. Write mask=8'hFF → ExtIRQ=1 with irq_id=2 one cycle after the write takes effect.
4. Commit and no preemption: during REQ on irq_id=4, raise irq_src[0] and write mask=8'h00 → ExtIRQ stays 1, irq_id=4 until ack. irq_src[0] remains pending=1 and is not requested while masked.
5. Long ack and set-wins: hold ExtIAck=1 for 6 cycles → exactly one pending bit cleared, FSM stays in HOLD until ExtIAck=0. A re-edge on the served source in the clear cycle leaves its pending bit=1.
6. Reset mid-operation: assert reset while ExtIRQ=1 and pending=8'h81 → ExtIRQ=0, pending=0, mask=8'hFF immediately, before the next clock edge.

Source files
------------

// File: rtl/ext_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : ext_irq_controller
// Description : Synchronizes and edge-detects external interrupt lines, masks
//               them, and issues one prioritized request at a time to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_irq_controller #(
    parameter int                 N_SRC      = 8,
    parameter int                 ID_W       = 3,
    parameter int                 HOLDOFF    = 4,
    parameter logic [N_SRC-1:0]   MASK_RESET = '1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               mask_we,
    input  logic [N_SRC-1:0]   mask_wdata,
    input  logic               ExtIAck,
    output logic               ExtIRQ,
    output logic [ID_W-1:0]    irq_id,
    output logic [N_SRC-1:0]   pending,
    output logic [N_SRC-1:0]   mask
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;
    localparam logic [7:0] c_HOLDOFF = 8'(HOLDOFF);

    logic [N_SRC-1:0] r_s1;
    logic [N_SRC-1:0] r_s2;
    logic [N_SRC-1:0] r_prv;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [1:0]       r_state;
    logic [7:0]       r_cnt;
    logic             r_irq;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_clr;
    logic [ID_W-1:0]  w_first_id;
    logic             w_any;

    assign w_rise     = r_s2 & ~r_prv;
    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;
    // Only the acknowledged source is cleared, and only in the ack cycle.
    assign w_clr      = ((r_state == c_REQ) && ExtIAck) ? (N_SRC'(1) << r_irq_id) : '0;

    // Downward scan so the lowest eligible index is the one that sticks.
    always_comb begin
        w_first_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_first_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_prv     <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RESET;
        end else begin
            r_s1      <= irq_src;
            r_s2      <= r_s1;
            r_prv     <= r_s2;
            // Set takes precedence over the acknowledge clear.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_irq_id <= w_first_id;
                        r_irq    <= 1'b1;
                        r_state  <= c_REQ;
                    end
                end
                c_REQ: begin
                    // Request is committed: id and line stay put until ack.
                    if (ExtIAck) begin
                        r_irq   <= 1'b0;
                        r_cnt   <= c_HOLDOFF;
                        r_state <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if ((r_cnt == 8'd0) && !ExtIAck) begin
                        r_state <= c_IDLE;
                    end else if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign ExtIRQ  = r_irq;
    assign irq_id  = r_irq_id;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_ext_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_irq_controller
// Description : Vector table, directed corner sequences and a randomized run
//               against a cycle-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_irq_controller;

    localparam int HOLDOFF = 4;

    typedef struct {
        logic [7:0] src;
        logic       ack;
        logic       exp_irq;
        logic [2:0] exp_id;
        logic [7:0] exp_pend;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic       we;
    logic [7:0] wdata;
    logic       iack;
    logic       xirq;
    logic [2:0] xid;
    logic [7:0] xpend;
    logic [7:0] xmask;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sampled input history indexed by edge number.
    logic [7:0] hist [0:2047];
    int         cyc;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic       m_irq;
    logic [2:0] m_id;
    logic       m_hold;
    int         m_hold_until;

    vec_t tbl [22];

    ext_irq_controller #(
        .N_SRC      (8),
        .ID_W       (3),
        .HOLDOFF    (HOLDOFF),
        .MASK_RESET (8'hFF)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .irq_src    (src),
        .mask_we    (we),
        .mask_wdata (wdata),
        .ExtIAck    (iack),
        .ExtIRQ     (xirq),
        .irq_id     (xid),
        .pending    (xpend),
        .mask       (xmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] s, input logic a, input logic i,
                                input logic [2:0] d, input logic [7:0] p);
        vec_t v;
        v.src = s; v.ack = a; v.exp_irq = i; v.exp_id = d; v.exp_pend = p;
        return v;
    endfunction

    function automatic logic [7:0] smp(input int k);
        return (k < 0) ? 8'h00 : hist[k];
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [7:0] rise;
        logic [7:0] clr;
        logic [7:0] elig;
        logic [7:0] iso;
        hist[cyc] = src;
        rise = smp(cyc - 2) & ~smp(cyc - 3);
        clr  = (m_irq && iack) ? (8'd1 << m_id) : 8'd0;
        elig = m_pend & m_mask;
        if (m_irq) begin
            if (iack) begin
                m_irq        = 1'b0;
                m_hold       = 1'b1;
                m_hold_until = cyc + HOLDOFF + 1;
            end
        end else if (m_hold) begin
            if (cyc >= m_hold_until && !iack) m_hold = 1'b0;
        end else if (elig != 8'd0) begin
            iso = elig & (~elig + 8'd1);
            for (int b = 0; b < 8; b++) if (iso[b]) m_id = 3'(b);
            m_irq = 1'b1;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (we) m_mask = wdata;
        cyc++;
    endtask

    // Called at posedge+1; resets, checks the asynchronous reset state, releases.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #2;
        chk({tag, "_irq"},  {31'd0, xirq}, 32'd0);
        chk({tag, "_pend"}, {24'd0, xpend}, 32'd0);
        chk({tag, "_mask"}, {24'd0, xmask}, 32'h0FF);
        chk({tag, "_id"},   {29'd0, xid},   32'd0);
        #2;
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; src = '0; we = 1'b0; wdata = '0; iack = 1'b0;
        tbl[0]  = mk(8'h20, 0, 0, 3'd0, 8'h00);
        tbl[1]  = mk(8'h20, 0, 0, 3'd0, 8'h00);
        tbl[2]  = mk(8'h20, 0, 0, 3'd0, 8'h20);
        tbl[3]  = mk(8'h00, 0, 1, 3'd5, 8'h20);
        tbl[4]  = mk(8'h00, 1, 0, 3'd5, 8'h00);
        for (int i = 5; i <= 9; i++) tbl[i] = mk(8'h00, 0, 0, 3'd5, 8'h00);
        tbl[10] = mk(8'h44, 0, 0, 3'd5, 8'h00);
        tbl[11] = mk(8'h44, 0, 0, 3'd5, 8'h00);
        tbl[12] = mk(8'h44, 0, 0, 3'd5, 8'h44);
        tbl[13] = mk(8'h00, 0, 1, 3'd2, 8'h44);
        tbl[14] = mk(8'h00, 1, 0, 3'd2, 8'h40);
        for (int i = 15; i <= 19; i++) tbl[i] = mk(8'h00, 0, 0, 3'd2, 8'h40);
        tbl[20] = mk(8'h00, 0, 1, 3'd6, 8'h40);
        tbl[21] = mk(8'h00, 1, 0, 3'd6, 8'h00);

        tick(2);
        reset_pulse("reset");

        // Single source then two simultaneous sources, cycle by cycle.
        for (int i = 0; i < 22; i++) begin
            src  = tbl[i].src;
            iack = tbl[i].ack;
            tick(1);
            chk($sformatf("vec%0d_irq", i),  {31'd0, xirq},  {31'd0, tbl[i].exp_irq});
            chk($sformatf("vec%0d_id", i),   {29'd0, xid},   {29'd0, tbl[i].exp_id});
            chk($sformatf("vec%0d_pend", i), {24'd0, xpend}, {24'd0, tbl[i].exp_pend});
        end
        iack = 1'b0; src = '0;

        // Masked source stays pending until the mask opens.
        tick(8);
        we = 1'b1; wdata = 8'hFB; tick(1); we = 1'b0;
        chk("mask_fb", {24'd0, xmask}, 32'hFB);
        src = 8'h04; tick(3);
        chk("masked_pend", {24'd0, xpend}, 32'h04);
        src = 8'h00; tick(2);
        chk("masked_noirq", {31'd0, xirq}, 32'd0);
        we = 1'b1; wdata = 8'hFF; tick(1); we = 1'b0;
        chk("unmask_edge_noirq", {31'd0, xirq}, 32'd0);
        tick(1);
        chk("unmask_irq", {31'd0, xirq}, 32'd1);
        chk("unmask_id",  {29'd0, xid},  32'd2);
        iack = 1'b1; tick(1); iack = 1'b0;
        chk("unmask_ack_pend", {24'd0, xpend}, 32'd0);

        // Committed request survives new arrivals and a mask write.
        tick(8);
        src = 8'h10; tick(3); src = 8'h00; tick(1);
        chk("commit_irq", {31'd0, xirq}, 32'd1);
        chk("commit_id",  {29'd0, xid},  32'd4);
        src = 8'h01; we = 1'b1; wdata = 8'h00; tick(1); we = 1'b0;
        tick(2); src = 8'h00; tick(3);
        chk("commit_hold_irq",  {31'd0, xirq},  32'd1);
        chk("commit_hold_id",   {29'd0, xid},   32'd4);
        chk("commit_hold_pend", {24'd0, xpend}, 32'h11);
        iack = 1'b1; tick(1); iack = 1'b0;
        chk("commit_ack_pend", {24'd0, xpend}, 32'h01);
        tick(10);
        chk("masked0_noirq", {31'd0, xirq},  32'd0);
        chk("masked0_pend",  {24'd0, xpend}, 32'h01);
        we = 1'b1; wdata = 8'hFF; tick(1); we = 1'b0; tick(1);
        chk("src0_irq", {31'd0, xirq}, 32'd1);
        chk("src0_id",  {29'd0, xid},  32'd0);
        iack = 1'b1; tick(1); iack = 1'b0;

        // Long acknowledge with a re-edge of the served source in the clear cycle.
        tick(8);
        src = 8'h0A; tick(3);
        chk("long_pend", {24'd0, xpend}, 32'h0A);
        src = 8'h00; tick(1);
        chk("long_irq", {31'd0, xirq}, 32'd1);
        chk("long_id",  {29'd0, xid},  32'd1);
        tick(2);
        src = 8'h02; tick(2);
        iack = 1'b1; tick(1);
        chk("setwins_irq",  {31'd0, xirq},  32'd0);
        chk("setwins_pend", {24'd0, xpend}, 32'h0A);
        tick(5);
        chk("longack_irq",  {31'd0, xirq},  32'd0);
        chk("longack_pend", {24'd0, xpend}, 32'h0A);
        iack = 1'b0; tick(1);
        chk("release_noirq", {31'd0, xirq}, 32'd0);
        tick(1);
        chk("rereq_irq", {31'd0, xirq}, 32'd1);
        chk("rereq_id",  {29'd0, xid},  32'd1);
        iack = 1'b1; tick(1); iack = 1'b0;
        chk("single_clear_pend", {24'd0, xpend}, 32'h08);
        src = 8'h00;

        // Asynchronous reset in the middle of a request.
        tick(1);
        reset_pulse("reset2");
        src = 8'h81; tick(3); src = 8'h00; tick(1);
        chk("pre_rst_irq",  {31'd0, xirq},  32'd1);
        chk("pre_rst_pend", {24'd0, xpend}, 32'h81);
        we = 1'b1; wdata = 8'h01; tick(1); we = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_irq",  {31'd0, xirq},  32'd0);
        chk("async_rst_pend", {24'd0, xpend}, 32'd0);
        chk("async_rst_mask", {24'd0, xmask}, 32'h0FF);
        #2;
        rst = 1'b0;
        tick(1);

        // Randomized run against the reference model.
        rst = 1'b1; src = '0; we = 1'b0; iack = 1'b0;
        tick(2);
        rst = 1'b0;
        cyc = 0; m_pend = '0; m_mask = 8'hFF; m_irq = 1'b0; m_id = '0;
        m_hold = 1'b0; m_hold_until = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
            we    = ($urandom_range(0, 15) == 0);
            wdata = 8'($urandom) | 8'($urandom);
            iack  = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_irq",  {31'd0, xirq},  {31'd0, m_irq});
            chk("rnd_id",   {29'd0, xid},   {29'd0, m_id});
            chk("rnd_pend", {24'd0, xpend}, {24'd0, m_pend});
            chk("rnd_mask", {24'd0, xmask}, {24'd0, m_mask});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
